// File: rtl/calc_pkg.sv
// Shared calculator definitions: operator codes and default digit geometry.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_code_t;

  localparam int DEFAULT_DIGIT_W    = 4;
  localparam int DEFAULT_NUM_DIGITS = 4;

  function automatic int operand_width(input int digit_w, input int num_digits);
    return digit_w * num_digits;
  endfunction

endpackage

// File: rtl/operand_bank_if.sv
// Keypad/ALU side bus of the operand bank; master drives commands, slave (the bank) drives state.
interface operand_bank_if
  import calc_pkg::*;
#(
  parameter int DIGIT_W      = DEFAULT_DIGIT_W,
  parameter int NUM_DIGITS   = DEFAULT_NUM_DIGITS,
  parameter int NUM_OPERANDS = 2,
  parameter int OP_W         = 2,
  parameter int HIST_DEPTH   = 4
);
  localparam int W      = operand_width(DIGIT_W, NUM_DIGITS);
  localparam int SEL_W  = $clog2(NUM_OPERANDS);
  localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
  localparam int HCNT_W = $clog2(HIST_DEPTH + 1);

  logic                      clear;
  logic [DIGIT_W-1:0]        digit;
  logic                      digit_valid;
  logic                      backspace;
  logic [SEL_W-1:0]          sel;
  logic [OP_W-1:0]           op_in;
  logic                      op_valid;
  logic [W-1:0]              result;
  logic                      result_valid;
  logic                      hist_recall;
  logic [NUM_OPERANDS*W-1:0] operands;
  logic [OP_W-1:0]           op_out;
  logic [CNT_W-1:0]          digit_cnt;
  logic                      entry_ovf;
  logic [HCNT_W-1:0]         hist_count;

  modport master (
    output clear, digit, digit_valid, backspace, sel, op_in, op_valid,
           result, result_valid, hist_recall,
    input  operands, op_out, digit_cnt, entry_ovf, hist_count
  );

  modport slave (
    input  clear, digit, digit_valid, backspace, sel, op_in, op_valid,
           result, result_valid, hist_recall,
    output operands, op_out, digit_cnt, entry_ovf, hist_count
  );

endinterface

// File: rtl/result_history.sv
// Ring buffer of past results with a recall pointer that walks from newest to oldest and wraps.
module result_history #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, newest, oldest;
  logic [CNT_W-1:0] count_q;
  logic             full;

  // Until the buffer first fills, the oldest entry still sits at index 0.
  assign full    = (count_q == CNT_W'(DEPTH));
  assign newest  = wr_ptr - 1'b1;
  assign oldest  = full ? wr_ptr : '0;
  assign rd_data = mem[rd_ptr];
  assign count   = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (push) begin
      mem[wr_ptr] <= push_data;
      rd_ptr      <= wr_ptr;
      wr_ptr      <= wr_ptr + 1'b1;
      if (!full) count_q <= count_q + 1'b1;
    end else if (pop) begin
      rd_ptr <= (rd_ptr == oldest) ? newest : rd_ptr - 1'b1;
    end
  end

endmodule

// File: rtl/operand_bank.sv
// Operand/operator storage between keypad decoder and ALU.
// Optional result history is compiled in with `define CALC_HISTORY_EN.
module operand_bank
  import calc_pkg::*;
#(
  parameter int DIGIT_W      = DEFAULT_DIGIT_W,
  parameter int NUM_DIGITS   = DEFAULT_NUM_DIGITS,
  parameter int NUM_OPERANDS = 2,
  parameter int OP_W         = 2,
  parameter int HIST_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          rst,
  operand_bank_if.slave bus
);
  localparam int W      = operand_width(DIGIT_W, NUM_DIGITS);
  localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
  localparam int HCNT_W = $clog2(HIST_DEPTH + 1);

  logic [W-1:0]              slot_q [NUM_OPERANDS];
  logic [CNT_W-1:0]          cnt_q  [NUM_OPERANDS];
  logic [NUM_OPERANDS-1:0]   fresh_q;
  logic [OP_W-1:0]           op_q;
  logic                      ovf_q;
  logic [NUM_OPERANDS*W-1:0] ops_flat;
  logic                      sel_ok, recall_cmd, recall_fire, push;
  logic [W-1:0]              hist_data;
  logic [HCNT_W-1:0]         hist_cnt;

  assign sel_ok = (32'(bus.sel) < 32'(NUM_OPERANDS));
  assign push   = bus.result_valid & ~bus.clear;

`ifdef CALC_HISTORY_EN
  localparam bit HIST_EN = 1'b1;

  result_history #(.W(W), .DEPTH(HIST_DEPTH)) u_hist (
    .clk       (clk),
    .rst       (rst),
    .clear     (bus.clear),
    .push      (push),
    .push_data (bus.result),
    .pop       (recall_fire),
    .rd_data   (hist_data),
    .count     (hist_cnt)
  );
`else
  localparam bit HIST_EN = 1'b0;

  assign hist_data = '0;
  assign hist_cnt  = '0;
`endif

  // A recall request takes its priority slot even when it turns out to be a no-op.
  assign recall_cmd  = bus.hist_recall & HIST_EN;
  assign recall_fire = recall_cmd & push == 1'b0 & ~bus.clear & sel_ok & (hist_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_OPERANDS; k++) begin
        slot_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
      fresh_q <= '0;
      op_q    <= '0;
      ovf_q   <= 1'b0;
    end else if (bus.clear) begin
      for (int k = 0; k < NUM_OPERANDS; k++) begin
        slot_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
      fresh_q <= '0;
      op_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (bus.op_valid) op_q <= bus.op_in;

      if (bus.result_valid) begin
        for (int k = 1; k < NUM_OPERANDS; k++) begin
          slot_q[k] <= '0;
          cnt_q[k]  <= '0;
        end
        slot_q[0]  <= bus.result;
        cnt_q[0]   <= CNT_W'(NUM_DIGITS);
        fresh_q    <= '0;
        fresh_q[0] <= 1'b1;
      end else if (recall_cmd) begin
        if (recall_fire) begin
          slot_q[bus.sel]  <= hist_data;
          cnt_q[bus.sel]   <= CNT_W'(NUM_DIGITS);
          fresh_q[bus.sel] <= 1'b1;
        end
      end else if (bus.backspace) begin
        if (sel_ok && fresh_q[bus.sel]) begin
          slot_q[bus.sel]  <= '0;
          cnt_q[bus.sel]   <= '0;
          fresh_q[bus.sel] <= 1'b0;
        end else if (sel_ok && cnt_q[bus.sel] != '0) begin
          slot_q[bus.sel] <= slot_q[bus.sel] >> DIGIT_W;
          cnt_q[bus.sel]  <= cnt_q[bus.sel] - 1'b1;
        end
      end else if (bus.digit_valid && sel_ok) begin
        // A fresh slot holds a result, so the first new digit starts a new number.
        if (fresh_q[bus.sel]) begin
          slot_q[bus.sel]  <= W'(bus.digit);
          cnt_q[bus.sel]   <= CNT_W'(1);
          fresh_q[bus.sel] <= 1'b0;
        end else if (cnt_q[bus.sel] < CNT_W'(NUM_DIGITS)) begin
          slot_q[bus.sel] <= (slot_q[bus.sel] << DIGIT_W) | W'(bus.digit);
          cnt_q[bus.sel]  <= cnt_q[bus.sel] + 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    ops_flat = '0;
    for (int k = 0; k < NUM_OPERANDS; k++) ops_flat[k*W +: W] = slot_q[k];
  end

  assign bus.operands   = ops_flat;
  assign bus.op_out     = op_q;
  assign bus.digit_cnt  = sel_ok ? cnt_q[bus.sel] : '0;
  assign bus.entry_ovf  = ovf_q;
  assign bus.hist_count = hist_cnt;

endmodule
